spi_master_xfer_core: RTL and testbench

//  SPI master shift engine with TX and RX FIFOs. It sits behind a register/bus wrapper.

---
 rtl/spi_master_xfer_core.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_spi_master_xfer_core.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer_core.sv
// rtl/spi_master_xfer_core.sv - SPI master shift engine with FWFT TX/RX FIFOs

// First-word-fall-through FIFO: rd_data shows the head whenever the FIFO is non-empty
module spi_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             wr_data,
  input  logic                     push,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// SPI master: pops TX words, shifts them out on sclk/mosi, writes received words to RX
module spi_master_xfer_core #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [7:0]  clk_div,
  input  logic [5:0]  word_len,
  input  logic        lsb_first,
  input  logic        loopback,
  input  logic [31:0] tx_data,
  input  logic        tx_push,
  output logic        tx_full,
  output logic        tx_almost_full,
  output logic [31:0] rx_data,
  input  logic        rx_pop,
  output logic        rx_empty,
  output logic        rx_almost_empty,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        busy,
  output logic        done_intr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [31:0]   tx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_empty, rx_full;
  logic          tx_pop, rx_push;

  logic [1:0]  state_q, state_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_intr_q, done_intr_d;
  logic [5:0]  len_q, len_d;
  logic        lsb_q, lsb_d;
  logic        cpha_q, cpha_d;
  logic        cpol_q, cpol_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [6:0]  edge_cnt_q, edge_cnt_d;
  logic [5:0]  tx_idx_q, tx_idx_d;
  logic [5:0]  rx_idx_q, rx_idx_d;
  logic [31:0] tx_word_q, tx_word_d;
  logic [31:0] rx_word_q, rx_word_d;

  logic [5:0]  eff_len;
  logic [6:0]  edge_nxt;
  logic        is_sample;
  logic        sample_bit;

  spi_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (tx_data),
    .push    (tx_push),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  spi_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (rx_word_q),
    .push    (rx_push),
    .pop     (rx_pop),
    .rd_data (rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign tx_almost_full  = (tx_count >= CW'(FIFO_DEPTH - 1));
  assign rx_almost_empty = (rx_count <= CW'(1));
  assign sclk            = sclk_q;
  assign mosi            = mosi_q;
  assign busy            = busy_q;
  assign done_intr       = done_intr_q;

  // Lengths above 32 cannot be shifted, so they fold to a full 32-bit word like 0 does
  assign eff_len    = (word_len == 6'd0 || word_len > 6'd32) ? 6'd32 : word_len;
  assign sample_bit = loopback ? mosi_q : miso;

  // Wire bit idx maps to word bit idx (LSB-first) or len-1-idx (MSB-first)
  function automatic logic [4:0] bit_pos(input logic [5:0] idx, input logic [5:0] len,
                                         input logic lsb);
    logic [5:0] p;
    p = lsb ? idx : (len - 6'd1 - idx);
    return p[4:0];
  endfunction

  // Transfer FSM: sequencing, sclk edge generation, bit drive and sample
  always_comb begin
    state_d     = state_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    done_intr_d = 1'b0;
    len_d       = len_q;
    lsb_d       = lsb_q;
    cpha_d      = cpha_q;
    cpol_d      = cpol_q;
    div_d       = div_q;
    div_cnt_d   = div_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    tx_idx_d    = tx_idx_q;
    rx_idx_d    = rx_idx_q;
    tx_word_d   = tx_word_q;
    rx_word_d   = rx_word_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    edge_nxt    = edge_cnt_q + 7'd1;
    // Odd edges are leading; cpha=0 samples on leading, cpha=1 on trailing
    is_sample   = (edge_nxt[0] != cpha_q);

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        if (enable && !tx_empty && !rx_full) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!enable) begin
          state_d = ST_IDLE;
          sclk_d  = cpol;
        end else begin
          tx_pop     = 1'b1;
          len_d      = eff_len;
          lsb_d      = lsb_first;
          cpha_d     = cpha;
          cpol_d     = cpol;
          div_d      = clk_div;
          div_cnt_d  = 8'd0;
          edge_cnt_d = 7'd0;
          rx_idx_d   = 6'd0;
          rx_word_d  = 32'd0;
          tx_word_d  = tx_head;
          sclk_d     = cpol;
          if (!cpha) begin
            // First bit must be on the wire before the leading (sampling) edge
            mosi_d   = tx_head[bit_pos(6'd0, eff_len, lsb_first)];
            tx_idx_d = 6'd1;
          end else begin
            tx_idx_d = 6'd0;
          end
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          sclk_d  = cpol;
        end else if (div_cnt_q == div_q) begin
          div_cnt_d  = 8'd0;
          edge_cnt_d = edge_nxt;
          sclk_d     = ~sclk_q;
          if (is_sample) begin
            rx_word_d[bit_pos(rx_idx_q, len_q, lsb_q)] = sample_bit;
            rx_idx_d = rx_idx_q + 6'd1;
          end else if (tx_idx_q < len_q) begin
            mosi_d   = tx_word_q[bit_pos(tx_idx_q, len_q, lsb_q)];
            tx_idx_d = tx_idx_q + 6'd1;
          end
          if (edge_nxt == {len_q, 1'b0}) begin
            state_d = ST_DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: begin
        rx_push     = 1'b1;
        done_intr_d = 1'b1;
        sclk_d      = cpol_q;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  // Transfer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_intr_q <= 1'b0;
      len_q       <= 6'd32;
      lsb_q       <= 1'b0;
      cpha_q      <= 1'b0;
      cpol_q      <= 1'b0;
      div_q       <= 8'd0;
      div_cnt_q   <= 8'd0;
      edge_cnt_q  <= 7'd0;
      tx_idx_q    <= 6'd0;
      rx_idx_q    <= 6'd0;
      tx_word_q   <= 32'd0;
      rx_word_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_intr_q <= done_intr_d;
      len_q       <= len_d;
      lsb_q       <= lsb_d;
      cpha_q      <= cpha_d;
      cpol_q      <= cpol_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      tx_idx_q    <= tx_idx_d;
      rx_idx_q    <= rx_idx_d;
      tx_word_q   <= tx_word_d;
      rx_word_q   <= rx_word_d;
    end
  end
endmodule

// File: tb/tb_spi_master_xfer_core.sv
// tb/tb_spi_master_xfer_core.sv - scoreboard bench for spi_master_xfer_core
module tb_spi_master_xfer_core;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [7:0]  clk_div = 8'd0;
  logic [5:0]  word_len = 6'd8;
  logic        lsb_first = 1'b0;
  logic        loopback = 1'b1;
  logic [31:0] tx_data = 32'd0;
  logic        tx_push = 1'b0;
  logic        rx_pop = 1'b0;
  logic        miso = 1'b0;
  logic        tx_full, tx_almost_full, rx_empty, rx_almost_empty;
  logic        sclk, mosi, busy, done_intr;
  logic [31:0] rx_data;

  spi_master_xfer_core #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .cpol            (cpol),
    .cpha            (cpha),
    .clk_div         (clk_div),
    .word_len        (word_len),
    .lsb_first       (lsb_first),
    .loopback        (loopback),
    .tx_data         (tx_data),
    .tx_push         (tx_push),
    .tx_full         (tx_full),
    .tx_almost_full  (tx_almost_full),
    .rx_data         (rx_data),
    .rx_pop          (rx_pop),
    .rx_empty        (rx_empty),
    .rx_almost_empty (rx_almost_empty),
    .sclk            (sclk),
    .mosi            (mosi),
    .miso            (miso),
    .busy            (busy),
    .done_intr       (done_intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tx;
    int          len;
    bit          lsb;
  } wire_t;

  int          errors = 0;
  int          checks = 0;
  wire_t       wire_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] slave_q[$];
  logic        mosi_bits[$];
  bit          mon_pop_en = 1'b0;
  int          done_cnt = 0;
  logic        first_bit = 1'b1;
  logic        cur_cpol = 1'b0;
  logic        cur_cpha = 1'b0;
  bit          cur_lsb = 1'b0;
  bit          cur_lb = 1'b1;
  int          cur_len = 8;
  logic        busy_prev = 1'b0;
  logic        sclk_prev = 1'b0;
  logic [31:0] slave_word = 32'd0;
  int          sk = 0;
  wire_t       mon_e;
  logic [31:0] mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int len);
    return (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
  endfunction

  function automatic int wpos(input int k);
    return cur_lsb ? k : (cur_len - 1 - k);
  endfunction

  // SPI slave model, wire capture and scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      rx_pop    = 1'b0;
      busy_prev = 1'b0;
      sclk_prev = sclk;
    end else begin
      if (busy && !busy_prev) begin
        slave_word = (slave_q.size() > 0) ? slave_q.pop_front() : 32'd0;
        sk = 0;
        if (!cur_cpha) begin
          miso = slave_word[wpos(0)];
          sk = 1;
        end
      end else if (busy && sclk !== sclk_prev && sclk == (cur_cpol ^ cur_cpha) && sk < cur_len) begin
        miso = slave_word[wpos(sk)];
        sk++;
      end
      if ((busy || busy_prev) && sclk !== sclk_prev && sclk == (cur_cpol ^ ~cur_cpha)) begin
        if (mosi_bits.size() == 0) first_bit = mosi;
        mosi_bits.push_back(mosi);
      end
      if (done_intr) begin
        done_cnt++;
        if (wire_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = wire_q.pop_front();
          mon_w = 32'd0;
          for (int i = 0; i < mosi_bits.size() && i < mon_e.len; i++) begin
            mon_w[mon_e.lsb ? i : (mon_e.len - 1 - i)] = mosi_bits[i];
          end
          chk("mosi_bit_count", 32'(mosi_bits.size()), 32'(mon_e.len));
          chk("mosi_word", mon_w, mon_e.tx & mask_of(mon_e.len));
        end
        mosi_bits.delete();
      end
      rx_pop = 1'b0;
      if (mon_pop_en && !rx_empty) begin
        if (rx_q.size() == 0) chk("unexpected_rx", rx_data, 32'hXXXX_XXXF);
        else chk("rx_data", rx_data, rx_q.pop_front());
        rx_pop = 1'b1;
      end
      busy_prev = busy;
      sclk_prev = sclk;
    end
  end

  task automatic set_mode(input int cp, input int ch, input int dv, input int ln,
                          input int ls, input int lb);
    @(negedge clk);
    cpol      = 1'(cp);
    cpha      = 1'(ch);
    clk_div   = 8'(dv);
    word_len  = 6'(ln);
    lsb_first = 1'(ls);
    loopback  = 1'(lb);
    cur_cpol  = 1'(cp);
    cur_cpha  = 1'(ch);
    cur_len   = (ln == 0) ? 32 : ln;
    cur_lsb   = (ls != 0);
    cur_lb    = (lb != 0);
  endtask

  task automatic push(input logic [31:0] w, input bit accept);
    logic [31:0] s;
    wire_t       e;
    s = $urandom;
    if (accept) begin
      e.tx = w; e.len = cur_len; e.lsb = cur_lsb;
      wire_q.push_back(e);
      slave_q.push_back(s);
      rx_q.push_back((cur_lb ? w : s) & mask_of(cur_len));
    end
    tx_data = w;
    tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic push_fc(input logic [31:0] w);
    int n = 0;
    while (tx_full && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_full_wait", 32'(n < 3000), 32'd1);
    push(w, 1'b1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((wire_q.size() != 0 || rx_q.size() != 0 || busy || !rx_empty) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < max), 32'd1);
  endtask

  task automatic wait_busy(input int max);
    int n = 0;
    while (!busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("busy_start", 32'(busy), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, bcnt, ln;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_intr), 32'd0);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_tx_af", 32'(tx_almost_full), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_rx_ae", 32'(rx_almost_empty), 32'd1);
    chk("rst_rx_data", rx_data, 32'd0);
    rst = 1'b0;

    // Directed words in mode 0, clk_div=4, loopback
    set_mode(0, 0, 4, 8, 0, 1);
    enable = 1'b1;
    mon_pop_en = 1'b1;
    push(32'h0000_00A5, 1'b1);
    drain(2000);
    chk("rx_empty_after_pop", 32'(rx_empty), 32'd1);

    set_mode(0, 0, 4, 16, 0, 1);
    push(32'h0000_1234, 1'b1);
    wait_busy(50);
    bcnt = 0;
    while (busy && bcnt < 2000) begin
      bcnt++;
      @(negedge clk);
    end
    chk("busy_cycles_16b", 32'(bcnt), 32'd160);
    drain(2000);

    set_mode(0, 0, 4, 32, 0, 1);
    push(32'hDEAD_BEEF, 1'b1);
    drain(2000);

    set_mode(0, 0, 4, 12, 1, 1);
    push(32'h0000_0ABC, 1'b1);
    drain(2000);
    chk("lsb_first_bit", 32'(first_bit), 32'd0);

    // TX FIFO fill with the core disabled
    set_mode(0, 0, 1, 8, 0, 1);
    enable = 1'b0;
    push(32'h11, 1'b1);
    push(32'h22, 1'b1);
    push(32'h33, 1'b1);
    chk("tx_af_after_3", 32'(tx_almost_full), 32'd1);
    chk("tx_full_after_3", 32'(tx_full), 32'd0);
    push(32'h44, 1'b1);
    chk("tx_full_after_4", 32'(tx_full), 32'd1);
    push(32'h55, 1'b0);
    chk("tx_full_after_5", 32'(tx_full), 32'd1);
    enable = 1'b1;
    drain(2000);

    // Randomized batches across all modes, loopback on and off
    for (int m = 0; m < 8; m++) begin
      ln = (m == 0) ? 1 : (m == 1) ? 0 : int'($urandom_range(1, 32));
      set_mode(m % 4 / 2, m % 2, int'($urandom_range(0, 3)), ln,
               int'($urandom_range(0, 1)), (m < 4) ? 1 : 0);
      repeat (2) @(negedge clk);
      chk("sclk_idle_level", 32'(sclk), 32'(cur_cpol));
      for (int k = 0; k < 4; k++) push_fc($urandom);
      drain(5000);
    end

    // RX full stalls the engine; TX keeps the remainder
    set_mode(0, 0, 0, 8, 0, 1);
    mon_pop_en = 1'b0;
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) push_fc($urandom);
    repeat (150) @(negedge clk);
    chk("stall_rx_ae", 32'(rx_almost_empty), 32'd0);
    chk("stall_busy", 32'(busy), 32'd0);
    chk("stall_done_cnt", 32'(done_cnt - d0), 32'd4);
    mon_pop_en = 1'b1;
    drain(2000);
    chk("stall_done_total", 32'(done_cnt - d0), 32'd6);

    // enable=0 mid-word abort
    set_mode(1, 0, 3, 16, 0, 1);
    d0 = done_cnt;
    push(32'h0000_C3C3, 1'b1);
    push(32'h0000_5A5A, 1'b1);
    wait_busy(50);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sclk", 32'(sclk), 32'd1);
    void'(wire_q.pop_front());
    void'(rx_q.pop_front());
    mosi_bits.delete();
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_rx_empty", 32'(rx_empty), 32'd1);
    enable = 1'b1;
    drain(2000);
    chk("abort_next_word", 32'(done_cnt - d0), 32'd1);

    // rst mid-word
    set_mode(1, 1, 3, 32, 0, 1);
    d0 = done_cnt;
    push($urandom, 1'b1);
    push($urandom, 1'b1);
    wait_busy(50);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_empty", 32'(rx_empty), 32'd1);
    chk("midrst_tx_af", 32'(tx_almost_full), 32'd0);
    chk("midrst_rx_data", rx_data, 32'd0);
    wire_q.delete();
    rx_q.delete();
    slave_q.delete();
    mosi_bits.delete();
    @(negedge clk);
    rst = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("post_rst_idle", 32'(bcnt), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_rx_empty", 32'(rx_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
